// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic jam controllers: FSM encodings and default
// timing constants used by the sensor filters and the jam sequencer.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_HOLD  = 2'd2
  } jam_state_e;

  localparam int DEF_DET_CYC  = 8;
  localparam int DEF_CLR_CYC  = 8;
  localparam int DEF_SLOT_CYC = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/jam_sensor_filter.sv
// Hysteresis filter for one road-occupancy sensor: the flag only changes after the
// raw input has disagreed with it for DET_CYC (set) or CLR_CYC (clear) cycles in a row.
module jam_sensor_filter
  import traffic_pkg::*;
#(
  parameter int DET_CYC = DEF_DET_CYC,
  parameter int CLR_CYC = DEF_CLR_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic flag
);

  localparam int CW = $clog2(max_int(DET_CYC, CLR_CYC) + 1);
  localparam logic [CW-1:0] DET_LAST = CW'(DET_CYC - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  logic [CW-1:0] cnt_q, cnt_d;
  logic          flag_q, flag_d;
  logic          disagree;

  always_comb begin
    cnt_d    = cnt_q;
    flag_d   = flag_q;
    disagree = (raw != flag_q);
    if (!disagree) begin
      cnt_d = '0;
    end else if (cnt_q == (flag_q ? CLR_LAST : DET_LAST)) begin
      flag_d = ~flag_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign flag = flag_q;

endmodule

// File: rtl/jam_ctrl_unit.sv
// Jam sequencer: qualifies the four road sensors and drives jam_op_en / jam_start /
// jam_rotation so service steps around the jammed roads once per slot.
module jam_ctrl_unit
  import traffic_pkg::*;
#(
  parameter int DET_CYC  = DEF_DET_CYC,
  parameter int CLR_CYC  = DEF_CLR_CYC,
  parameter int SLOT_CYC = DEF_SLOT_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sensor_raw,
  input  logic       jam_ctrl_en,
  output logic       jam_sensor_0,
  output logic       jam_sensor_1,
  output logic       jam_sensor_2,
  output logic       jam_sensor_3,
  output logic       jam_op_en,
  output logic       jam_start,
  output logic       jam_rotation
);

  localparam int SW = $clog2(SLOT_CYC);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYC - 1);

  logic [3:0]    flag;
  logic          any_flag;
  jam_state_e    state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic          op_en_q, op_en_d;
  logic          start_q, start_d;
  logic          rot_q, rot_d;

  for (genvar i = 0; i < 4; i++) begin : g_filt
    jam_sensor_filter #(
      .DET_CYC(DET_CYC),
      .CLR_CYC(CLR_CYC)
    ) u_filt (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (sensor_raw[i]),
      .flag (flag[i])
    );
  end

  assign any_flag = |flag;

  // Outputs are computed one edge early so they appear registered; the rotation
  // decision is taken in the slot's last cycle and the pulse lands on the next one.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    op_en_d = 1'b0;
    start_d = 1'b0;
    rot_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        slot_d = '0;
        if (jam_ctrl_en && any_flag) begin
          state_d = ST_START;
          op_en_d = 1'b1;
          start_d = 1'b1;
        end
      end
      ST_START: begin
        if (!jam_ctrl_en) begin
          state_d = ST_IDLE;
          slot_d  = '0;
        end else begin
          state_d = ST_HOLD;
          op_en_d = 1'b1;
          slot_d  = slot_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (!jam_ctrl_en) begin
          state_d = ST_IDLE;
          slot_d  = '0;
        end else if (slot_q == SLOT_LAST) begin
          slot_d = '0;
          if (any_flag) begin
            op_en_d = 1'b1;
            rot_d   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          op_en_d = 1'b1;
          slot_d  = slot_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        slot_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      op_en_q <= 1'b0;
      start_q <= 1'b0;
      rot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      op_en_q <= op_en_d;
      start_q <= start_d;
      rot_q   <= rot_d;
    end
  end

  assign jam_sensor_0 = flag[0];
  assign jam_sensor_1 = flag[1];
  assign jam_sensor_2 = flag[2];
  assign jam_sensor_3 = flag[3];
  assign jam_op_en    = op_en_q;
  assign jam_start    = start_q;
  assign jam_rotation = rot_q;

endmodule

// File: tb/tb_jam_ctrl_unit.sv
// Self-checking bench for jam_ctrl_unit: cycle scoreboard plus directed latency checks.
module tb_jam_ctrl_unit;

  localparam int DET  = 8;
  localparam int CLR  = 8;
  localparam int SLOT = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sensor_raw;
  logic       jam_ctrl_en;
  logic       jam_sensor_0, jam_sensor_1, jam_sensor_2, jam_sensor_3;
  logic       jam_op_en, jam_start, jam_rotation;

  always #5 clk = ~clk;

  jam_ctrl_unit #(.DET_CYC(DET), .CLR_CYC(CLR), .SLOT_CYC(SLOT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sensor_raw  (sensor_raw),
    .jam_ctrl_en (jam_ctrl_en),
    .jam_sensor_0(jam_sensor_0),
    .jam_sensor_1(jam_sensor_1),
    .jam_sensor_2(jam_sensor_2),
    .jam_sensor_3(jam_sensor_3),
    .jam_op_en   (jam_op_en),
    .jam_start   (jam_start),
    .jam_rotation(jam_rotation)
  );

  typedef struct packed {
    logic [3:0] flags;
    logic       op_en;
    logic       start;
    logic       rot;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int         m_cnt[4];
  logic [3:0] m_flag;
  int         m_state;
  int         m_slot;
  logic       m_op, m_st, m_rot;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, advance the reference model, and compare after the edge.
  task automatic step(input logic rst_v, input logic en_v, input logic [3:0] raw_v);
    exp_t e;
    exp_t got;
    logic anyf;
    int   ns, nslot;
    logic n_op, n_st, n_rot;
    @(negedge clk);
    rst_n       = rst_v;
    jam_ctrl_en = en_v;
    sensor_raw  = raw_v;
    if (!rst_v) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_flag = 4'h0; m_state = 0; m_slot = 0;
      m_op = 1'b0; m_st = 1'b0; m_rot = 1'b0;
    end else begin
      anyf = |m_flag;
      ns = m_state; nslot = m_slot;
      n_op = 1'b0; n_st = 1'b0; n_rot = 1'b0;
      case (m_state)
        0: begin
          nslot = 0;
          if (en_v && anyf) begin ns = 1; n_op = 1'b1; n_st = 1'b1; end
        end
        1: begin
          if (!en_v) begin ns = 0; nslot = 0; end
          else begin ns = 2; n_op = 1'b1; nslot = 1; end
        end
        default: begin
          if (!en_v) begin ns = 0; nslot = 0; end
          else if (m_slot == SLOT - 1) begin
            nslot = 0;
            if (anyf) begin n_op = 1'b1; n_rot = 1'b1; end
            else ns = 0;
          end else begin
            n_op = 1'b1; nslot = m_slot + 1;
          end
        end
      endcase
      for (int i = 0; i < 4; i++) begin
        if (raw_v[i] != m_flag[i]) begin
          m_cnt[i]++;
          if (m_cnt[i] == (m_flag[i] ? CLR : DET)) begin
            m_flag[i] = ~m_flag[i];
            m_cnt[i]  = 0;
          end
        end else begin
          m_cnt[i] = 0;
        end
      end
      m_state = ns; m_slot = nslot;
      m_op = n_op; m_st = n_st; m_rot = n_rot;
    end
    e.flags = m_flag; e.op_en = m_op; e.start = m_st; e.rot = m_rot;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check_val("flags", {jam_sensor_3, jam_sensor_2, jam_sensor_1, jam_sensor_0}, got.flags);
    check_val("op_en", jam_op_en, got.op_en);
    check_val("start", jam_start, got.start);
    check_val("rotation", jam_rotation, got.rot);
    check_val("excl", jam_start & jam_rotation, 0);
    check_val("pulse_no_op", (jam_start | jam_rotation) & ~jam_op_en, 0);
  endtask

  int lat, rot1, rot2, rot_seen;

  initial begin
    rst_n = 1'b0; jam_ctrl_en = 1'b1; sensor_raw = 4'hF;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_flag = 4'h0; m_state = 0; m_slot = 0;
    m_op = 1'b0; m_st = 1'b0; m_rot = 1'b0;

    // 1: reset holds everything low, flags rise DET cycles after release
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 4'hF);
    check_val("rst_outputs", {jam_sensor_3, jam_sensor_2, jam_sensor_1, jam_sensor_0,
                              jam_op_en, jam_start, jam_rotation}, 0);
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, 1'b0, 4'hF);
      if (jam_sensor_0 && lat == 0) lat = k;
    end
    check_val("rise_lat", lat, 8);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 4'h0);
    check_val("flags_cleared", {jam_sensor_3, jam_sensor_2, jam_sensor_1, jam_sensor_0}, 0);

    // 2: a 7-cycle pulse is rejected, an 8-cycle one is accepted on cycle 8
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 4'b0100);
    step(1'b1, 1'b0, 4'b0000);
    check_val("glitch_flag2", jam_sensor_2, 0);
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, 1'b0, 4'b0100);
      if (jam_sensor_2 && lat == 0) lat = k;
    end
    check_val("flag2_lat", lat, 8);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 4'b0000);

    // 3: entry and periodic rotation
    for (int k = 0; k < 9; k++) step(1'b1, 1'b0, 4'b0010);
    check_val("flag1_set", jam_sensor_1, 1);
    step(1'b1, 1'b1, 4'b0010);
    check_val("entry_start", {jam_op_en, jam_start}, 2'b11);
    rot1 = 0; rot2 = 0;
    for (int i = 1; i <= 32; i++) begin
      step(1'b1, 1'b1, 4'b0010);
      if (i == 1) check_val("start_one_cycle", jam_start, 0);
      if (jam_rotation) begin
        if (rot1 == 0) rot1 = i;
        else if (rot2 == 0) rot2 = i;
      end
    end
    check_val("rot_first", rot1, 16);
    check_val("rot_second", rot2, 32);

    // 4: all roads clear -> flags drop, next slot end exits without a pulse
    lat = 0; rot_seen = 0;
    for (int j = 1; j <= 40 && lat == 0; j++) begin
      step(1'b1, 1'b1, 4'b0000);
      if (jam_rotation) rot_seen++;
      if (!jam_op_en) lat = j;
    end
    check_val("exit_lat", lat, 16);
    check_val("exit_rot", rot_seen, 0);

    // 5: jam_ctrl_en drops on the slot-end tick
    for (int k = 0; k < 9; k++) step(1'b1, 1'b0, 4'b0001);
    step(1'b1, 1'b1, 4'b0001);
    check_val("abort_entry", jam_start, 1);
    for (int i = 1; i <= 15; i++) step(1'b1, 1'b1, 4'b0001);
    step(1'b1, 1'b0, 4'b0001);
    check_val("abort_outs", {jam_op_en, jam_rotation}, 0);
    step(1'b1, 1'b1, 4'b0001);
    check_val("reentry_start", {jam_op_en, jam_start}, 2'b11);

    // 6: reset in the middle of a slot, then a full rebuild
    for (int i = 1; i <= 10; i++) step(1'b1, 1'b1, 4'b0001);
    step(1'b0, 1'b1, 4'b0001);
    check_val("midrst_outs", {jam_sensor_0, jam_op_en, jam_start, jam_rotation}, 0);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      step(1'b1, 1'b1, 4'b0001);
      if (jam_start) lat = k;
    end
    check_val("midrst_start_lat", lat, 9);
    rot1 = 0;
    for (int i = 1; i <= 17; i++) begin
      step(1'b1, 1'b1, 4'b0001);
      if (jam_rotation && rot1 == 0) rot1 = i;
    end
    check_val("midrst_rot", rot1, 16);

    check_val("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
